// File: rtl/multicycle_control_pkg.sv
// Shared MIPS encodings and state type for the multi-cycle control unit.
package multicycle_control_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] BNE    = 6'b000101;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] JAL    = 6'b000011;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    // pc_src encodings
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL_WB,
        S_JR,
        S_HALT
    } ctrl_state_t;

    // States that hold a memory strobe and wait on mem_ready
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles a memory access has been stalled and flags the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_mem_i,
    input  logic             mem_ready_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] wait_cnt_o,
    output logic             timeout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    assign waiting    = in_mem_i && !mem_ready_i;
    // A ready on the limit cycle suppresses the timeout, so the access completes.
    assign timeout_o  = waiting && (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign wait_cnt_o = cnt_q;

    // Restart on every state change, count stalled memory cycles otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction and drives datapath controls.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem2reg,
    output logic               reg_write,
    output logic               jal,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sign_xtend,
    output logic               illegal,
    output logic               bus_error,
    output logic               busy
);

    ctrl_state_t      state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_mem_i    (is_mem_state(state_q)),
        .mem_ready_i (mem_ready),
        .clear_i     (state_d != state_q),
        .wait_cnt_o  (wait_cnt),
        .timeout_o   (timeout)
    );

    // Next-state selection and sticky fault flags
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = (state_q == S_FETCH)  ? S_DECODE :
                              (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (timeout) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    R_TYPE:   state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
                    LW, SW:   state_d = S_MEM_ADDR;
                    ADDI:     state_d = S_EXEC_I;
                    BEQ, BNE: state_d = S_BRANCH;
                    J:        state_d = S_JUMP;
                    JAL:      state_d = S_JAL_WB;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode == SW) ? S_MEM_WR : S_MEM_RD;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // State and fault flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Per-state datapath controls; forced idle while reset is held so strobes drop at once
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        reg_write  = 1'b0;
        jal        = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_W'(ALU_ADD);
        sign_xtend = 1'b0;
        busy       = 1'b0;
        illegal    = illegal_q;
        bus_error  = bus_error_q;
        if (rst_n) begin
            busy = (state_q != S_FETCH) || (wait_cnt != '0);
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Branch offsets are signed, so the target precompute sign-extends
                    alu_src_b  = SRCB_IMM_SL;
                    sign_xtend = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALUOP_W'(ALU_FUNCT);
                    sign_xtend = ~funct[0];
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    sign_xtend = 1'b1;
                end
                S_I_WB: reg_write = 1'b1;
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem2reg   = 1'b1;
                    reg_write = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_W'(ALU_SUB);
                    pc_src    = PC_SRC_BRANCH;
                    pc_write  = (opcode == BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                end
                S_JAL_WB: begin
                    pc_src    = PC_SRC_JUMP;
                    pc_write  = 1'b1;
                    jal       = 1'b1;
                    reg_write = 1'b1;
                end
                S_JR: begin
                    pc_src   = PC_SRC_RS;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model feeds expected
// per-cycle controls into a queue; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int T = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       reg_write;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       sign_xtend;
        logic       illegal;
        logic       bus_error;
        logic       busy;
    } ctl_t;

    typedef struct {
        logic       rst_n;
        logic       rst_mid;
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        logic [5:0] fn;
        ctl_t       exp;
        ctl_t       care;
        string      tag;
    } cyc_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_write;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       sign_xtend;
    logic       illegal;
    logic       bus_error;
    logic       busy;

    ctl_t act;
    cyc_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc_no;
    logic m_ill;
    logic m_bus;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;

    multicycle_control #(
        .ALUOP_W     (3),
        .MEM_TIMEOUT (T),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .reg_write  (reg_write),
        .jal        (jal),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .sign_xtend (sign_xtend),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .busy       (busy)
    );

    assign act = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem2reg,
                  reg_write, jal, alu_src_a, alu_src_b, alu_op, sign_xtend, illegal, bus_error, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    // Monitor: every driven cycle has one expected control word
    initial begin
        cyc_t c;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                c = exp_q.pop_front();
                checks++;
                if (((act ^ c.exp) & c.care) !== '0) begin
                    errors++;
                    $display("FAIL %s cycle %0d: actual=%h required=%h care=%h", c.tag, cyc_no,
                             act, c.exp, c.care);
                end
                cyc_no++;
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    endfunction

    function automatic logic [5:0] pick_legal();
        case ($urandom_range(0, 9))
            0, 1, 2: return OP_R;
            3:       return OP_ADDI;
            4:       return OP_LW;
            5:       return OP_SW;
            6:       return OP_BEQ;
            7:       return OP_BNE;
            8:       return OP_J;
            default: return OP_JAL;
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return T + 1;
        if (r == 1) return T;
        return $urandom_range(0, 3);
    endfunction

    // Controls in a running (non-reset) cycle before per-phase fields are added
    function automatic ctl_t base();
        ctl_t e;
        e           = '0;
        e.alu_op    = 3'b010;
        e.busy      = 1'b1;
        e.illegal   = m_ill;
        e.bus_error = m_bus;
        return e;
    endfunction

    function automatic ctl_t reset_exp();
        ctl_t e;
        e        = '0;
        e.alu_op = 3'b010;
        return e;
    endfunction

    task automatic drive(input cyc_t c);
        @(posedge clk);
        #1;
        rst_n     = c.rst_n;
        opcode    = c.op;
        funct     = c.fn;
        zero      = c.zero;
        mem_ready = c.rdy;
        exp_q.push_back(c);
        if (c.rst_mid) begin
            #2;
            rst_n = 1'b0;
        end
    endtask

    task automatic step(input string tag, input ctl_t e, input logic rdy, input logic z,
                        input logic sx_care);
        cyc_t c;
        c.rst_n           = 1'b1;
        c.rst_mid         = 1'b0;
        c.rdy             = rdy;
        c.zero            = z;
        c.op              = cur_op;
        c.fn              = cur_fn;
        c.exp             = e;
        c.care            = '1;
        c.care.sign_xtend = sx_care;
        c.tag             = tag;
        drive(c);
    endtask

    task automatic reset_cycle(input logic mid);
        cyc_t c;
        m_ill     = 1'b0;
        m_bus     = 1'b0;
        c.rst_n   = mid;
        c.rst_mid = mid;
        c.rdy     = rb();
        c.zero    = rb();
        c.op      = cur_op;
        c.fn      = cur_fn;
        c.exp     = reset_exp();
        c.care    = '1;
        c.tag     = mid ? "RESET_MID" : "RESET";
        drive(c);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) reset_cycle(1'b0);
    endtask

    task automatic halt(input int n);
        for (int i = 0; i < n; i++) step("HALT", base(), rb(), rb(), 1'b1);
    endtask

    // Memory access of w stall cycles (w > T means never ready); st: 0 done, 1 timeout, 2 reset cut in
    task automatic mem_phase(input string tag, input ctl_t eb, input logic is_fetch, input int w,
                             input int cut, output int st);
        for (int i = 0; i <= T; i++) begin
            ctl_t e;
            logic r;
            if (i == cut) begin
                reset_cycle(1'b1);
                st = 2;
                return;
            end
            r = (i == w);
            e = eb;
            if (is_fetch) begin
                e.busy     = (i != 0);
                e.pc_write = r;
                e.ir_write = r;
            end
            step(tag, e, r, rb(), 1'b1);
            if (r) begin
                st = 0;
                return;
            end
        end
        m_bus = 1'b1;
        st    = 1;
    endtask

    // One instruction: fetch, decode, then the class-specific tail
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                            input int zb, input int cut, output int st);
        ctl_t e;
        int   ms;
        logic z;
        cur_op = op;
        cur_fn = fn;
        st     = 0;
        e           = base();
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'd1;
        mem_phase("FETCH", e, 1'b1, fw, -1, ms);
        if (ms != 0) begin
            st = ms;
            return;
        end
        e           = base();
        e.alu_src_b = 2'd3;
        step("DECODE", e, rb(), rb(), 1'b0);
        if (op == OP_R && fn == FN_JR) begin
            e          = base();
            e.pc_src   = 2'd3;
            e.pc_write = 1'b1;
            step("JR", e, rb(), rb(), 1'b1);
        end else if (op == OP_R) begin
            e            = base();
            e.alu_src_a  = 1'b1;
            e.alu_op     = 3'b111;
            e.sign_xtend = ~fn[0];
            step("EXEC_R", e, rb(), rb(), 1'b1);
            e           = base();
            e.reg_dst   = 1'b1;
            e.reg_write = 1'b1;
            step("R_WB", e, rb(), rb(), 1'b1);
        end else if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
            e            = base();
            e.alu_src_a  = 1'b1;
            e.alu_src_b  = 2'd2;
            e.sign_xtend = 1'b1;
            step((op == OP_ADDI) ? "EXEC_I" : "MEM_ADDR", e, rb(), rb(), 1'b1);
            if (op == OP_ADDI) begin
                e           = base();
                e.reg_write = 1'b1;
                step("I_WB", e, rb(), rb(), 1'b1);
            end else begin
                e        = base();
                e.i_or_d = 1'b1;
                if (op == OP_LW) e.mem_read = 1'b1;
                else             e.mem_write = 1'b1;
                mem_phase((op == OP_LW) ? "MEM_RD" : "MEM_WR", e, 1'b0, mw, cut, ms);
                if (ms != 0) begin
                    st = ms;
                    return;
                end
                if (op == OP_LW) begin
                    e           = base();
                    e.mem2reg   = 1'b1;
                    e.reg_write = 1'b1;
                    step("MEM_WB", e, rb(), rb(), 1'b1);
                end
            end
        end else if (op == OP_BEQ || op == OP_BNE) begin
            z           = (zb > 1) ? rb() : zb[0];
            e           = base();
            e.alu_src_a = 1'b1;
            e.alu_op    = 3'b110;
            e.pc_src    = 2'd1;
            e.pc_write  = (op == OP_BEQ) ? z : ~z;
            step("BRANCH", e, rb(), z, 1'b1);
        end else if (op == OP_J || op == OP_JAL) begin
            e          = base();
            e.pc_src   = 2'd2;
            e.pc_write = 1'b1;
            if (op == OP_JAL) begin
                e.jal       = 1'b1;
                e.reg_write = 1'b1;
            end
            step((op == OP_J) ? "JUMP" : "JAL_WB", e, rb(), rb(), 1'b1);
        end else begin
            m_ill = 1'b1;
            st    = 1;
        end
    endtask

    initial begin
        int st;
        checks    = 0;
        errors    = 0;
        cyc_no    = 0;
        m_ill     = 1'b0;
        m_bus     = 1'b0;
        cur_op    = '0;
        cur_fn    = '0;
        rst_n     = 1'b0;
        opcode    = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        do_reset(3);

        // Directed sequences
        do_instr(OP_ADDI, 6'h15, 0, 0, 2, -1, st);
        do_instr(OP_LW, 6'h00, 0, 3, 2, -1, st);
        do_instr(OP_BNE, 6'h00, 0, 0, 1, -1, st);
        do_instr(OP_BNE, 6'h00, 0, 0, 0, -1, st);
        do_instr(OP_BEQ, 6'h00, 1, 0, 1, -1, st);
        do_instr(OP_JAL, 6'h00, 0, 0, 2, -1, st);
        do_instr(OP_R, FN_JR, 0, 0, 2, -1, st);
        do_instr(OP_R, 6'h21, 2, 0, 2, -1, st);
        do_instr(OP_J, 6'h00, 0, 0, 2, -1, st);

        do_instr(6'b111111, 6'h00, 0, 0, 2, -1, st);
        halt(20);
        do_reset(2);

        do_instr(OP_SW, 6'h00, 0, T + 1, 2, -1, st);
        halt(4);
        do_reset(2);

        do_instr(OP_SW, 6'h00, 0, T, 2, -1, st);
        do_instr(OP_LW, 6'h00, T, 2, 2, -1, st);
        do_instr(OP_ADDI, 6'h00, T + 1, 0, 2, -1, st);
        halt(3);
        do_reset(1);

        do_instr(OP_SW, 6'h00, 0, 10, 2, 5, st);
        do_reset(2);
        do_instr(OP_R, 6'h20, 0, 0, 2, -1, st);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            if ($urandom_range(0, 99) < 6) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = pick_legal();
            end
            fn = 6'($urandom);
            if (op == OP_R && $urandom_range(0, 3) == 0) fn = FN_JR;
            do_instr(op, fn, pick_wait(), pick_wait(), 2, -1, st);
            if (st == 1) begin
                halt($urandom_range(1, 4));
                do_reset($urandom_range(1, 2));
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (exp_q.size() != 0) begin
            $display("FAIL: %0d expected cycles never compared", exp_q.size());
            $fatal(1);
        end
        if (checks <= 100) begin
            $display("FAIL: only %0d checks performed", checks);
            $fatal(1);
        end
        if (errors != 0) begin
            $display("FAIL: %0d mismatches", errors);
            $fatal(1);
        end
        $display("PASS");
        $finish;
    end

endmodule
